fir_datapath: RTL and testbench
===============================

FIR_DATAPATH -- requirements
Module: fir_datapath

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port n_reset, input, 1 bit: reset, synchronous and active-low, sampled on the clk rising edge.
REQ-003 The block SHALL have port op, input, 2 bits: operation select (0 NOP, 1 COPY, 2 LOAD, 3 ADD).
REQ-004 The block SHALL have port src1, input, 4 bits: first source register index.
REQ-005 The block SHALL have port src2, input, 4 bits: second source register index.
REQ-006 The block SHALL have port dest, input, 4 bits: destination register index.
REQ-007 The block SHALL have port ext_data, input, 16 bits: incoming sample, written by LOAD.
REQ-008 The block SHALL have port overflow, output, 1 bit: combinational signed-overflow flag of the current ADD.
REQ-009 The block SHALL have port ovf_sticky, output, 1 bit: registered flag, set by any committed overflowing ADD.
REQ-010 The block SHALL have port outreg_data, output, 16 bits: continuous copy of register 0 (filter result).

Function
REQ-011 The block SHALL hold 16 registers r0..r15, each 16-bit two's complement.
REQ-012 Reads SHALL be combinational and asynchronous: A = r[src1], B = r[src2].
REQ-013 NOP (op=0): no register SHALL change, including when dest = 4'hf.
REQ-014 COPY (op=1): r[dest] SHALL take A at the next rising edge.
REQ-015 LOAD (op=2): r[dest] SHALL take ext_data at the next rising edge.
REQ-016 ADD (op=3): r[dest] SHALL take (A + B) mod 2^16 at the next rising edge; the result SHALL be written even on overflow.
REQ-017 Write latency SHALL be exactly one cycle; a read in the cycle after a write to the same index SHALL return the new value.
REQ-018 Within a cycle, a read SHALL return the pre-edge value even when src1 or src2 equals dest.
REQ-019 When src1 = src2 = dest under ADD, r[dest] SHALL become 2*old mod 2^16.
REQ-020 overflow SHALL be 1 only when op=3, A[15]=B[15], and sum[15]!=A[15]; otherwise 0.
REQ-021 overflow SHALL be valid in the same cycle op/src are presented, so a state machine can branch on it that cycle.
REQ-022 ovf_sticky SHALL set to 1 at the rising edge ending a cycle where overflow=1.
REQ-023 ovf_sticky SHALL clear to 0 at the rising edge ending a LOAD cycle with no overflow in that cycle.
REQ-024 Otherwise ovf_sticky SHALL hold its value.
REQ-025 outreg_data SHALL equal r0 at all times, updating one cycle after a write to r0.
REQ-026 Out-of-range op values cannot occur; op is fully decoded with no default write.

Reset
REQ-027 While n_reset=0 at a rising edge, all r0..r15 SHALL become 16'h0000 and ovf_sticky SHALL become 0.
REQ-028 Reset SHALL take priority over any op in the same cycle; no write SHALL occur.
REQ-029 During and after reset, outreg_data SHALL read 16'h0000 and overflow SHALL follow REQ-020 combinationally (0 for zero operands).
REQ-030 Reset asserted mid-sequence (e.g. between two ADDs) SHALL discard all partial results.

Verification
REQ-031 LOAD r7 <- 16'h1234, then COPY r3 <- r7 -> r3=16'h1234 one cycle after COPY; r7 unchanged.
REQ-032 r3=16'h0005, r4=16'h0003, ADD r2 <- r3+r4 -> r2=16'h0008, overflow=0 during ADD, ovf_sticky=0.
REQ-033 r3=16'h7FFF, r4=16'h0001, ADD r2 -> overflow=1 same cycle, r2=16'h8000, ovf_sticky=1 next cycle; subsequent LOAD -> ovf_sticky=0.
REQ-034 r3=16'h8000, r4=16'hFFFF, ADD -> overflow=1, result 16'h7FFF; r3=16'hFFFF, r4=16'h0001 -> overflow=0, result 16'h0000.
REQ-035 Full sequence: LOAD r7; COPY r3<-r4, r4<-r5, r5<-r6, r6<-r7; ADD r2<-r3+r4, r1<-r2+r5, r0<-r1+r6 -> outreg_data equals the sum of the four latest samples.
REQ-036 Reset asserted with op=LOAD dest=5 -> r5 stays 16'h0000, all registers zero, ovf_sticky=0.

Source files
------------

// File: rtl/fir_datapath.sv
// ---------------------------------------------------------------------------
// fir_datapath: 16 x 16-bit register file with COPY/LOAD/ADD datapath for FIR.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_datapath (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [1:0]  op,
  input  logic [3:0]  src1,
  input  logic [3:0]  src2,
  input  logic [3:0]  dest,
  input  logic [15:0] ext_data,
  output logic        overflow,
  output logic        ovf_sticky,
  output logic [15:0] outreg_data
);

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_ADD  = 2'd3;

  logic [15:0] regs [16];
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] sum;
  logic [15:0] wr_data;
  logic        wr_en;

  assign opa = regs[src1];
  assign opb = regs[src2];
  assign sum = opa + opb;

  // Same-sign operands producing a different-sign result.
  assign overflow = (op == OP_ADD) && (opa[15] == opb[15]) && (sum[15] != opa[15]);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = 16'h0000;
    case (op)
      OP_NOP: begin
        wr_en   = 1'b0;
        wr_data = 16'h0000;
      end
      OP_COPY: begin
        wr_en   = 1'b1;
        wr_data = opa;
      end
      OP_LOAD: begin
        wr_en   = 1'b1;
        wr_data = ext_data;
      end
      OP_ADD: begin
        wr_en   = 1'b1;
        wr_data = sum;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'h0000;
      end
      ovf_sticky <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[dest] <= wr_data;
      end
      // Overflow wins over the LOAD-clear.
      if (overflow) begin
        ovf_sticky <= 1'b1;
      end else if (op == OP_LOAD) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

  assign outreg_data = regs[0];

endmodule

`default_nettype wire

// File: tb/tb_fir_datapath.sv
// ---------------------------------------------------------------------------
// tb_fir_datapath: scoreboard bench for fir_datapath with a reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_datapath;

  logic        clk;
  logic        n_reset;
  logic [1:0]  op;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  dest;
  logic [15:0] ext_data;
  logic        overflow;
  logic        ovf_sticky;
  logic [15:0] outreg_data;

  typedef struct {
    logic [15:0] out;
    logic        sticky;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model [16];
  logic        m_sticky;
  int          checks;
  int          errors;
  logic [15:0] hist [4];

  fir_datapath dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .dest       (dest),
    .ext_data   (ext_data),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky),
    .outreg_data(outreg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check the combinational flag, push post-edge state.
  task automatic drive(input string tag, input logic rn, input logic [1:0] o,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input logic [15:0] x);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        ovf;
    exp_t        e;
    @(negedge clk);
    n_reset  = rn;
    op       = o;
    src1     = s1;
    src2     = s2;
    dest     = d;
    ext_data = x;
    a   = model[s1];
    b   = model[s2];
    s   = a + b;
    ovf = (o == 2'd3) && (a[15] == b[15]) && (s[15] != a[15]);
    #1;
    check({tag, ".ovf"}, {15'b0, overflow}, {15'b0, ovf});
    if (!rn) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      m_sticky = 1'b0;
    end else begin
      case (o)
        2'd1: model[d] = a;
        2'd2: model[d] = x;
        2'd3: model[d] = s;
        default: ;
      endcase
      if (ovf) m_sticky = 1'b1;
      else if (o == 2'd2) m_sticky = 1'b0;
    end
    e.out    = model[0];
    e.sticky = m_sticky;
    e.tag    = tag;
    sb_q.push_back(e);
  endtask

  task automatic ld(input logic [3:0] d, input logic [15:0] x);
    drive("load", 1'b1, 2'd2, 4'd0, 4'd0, d, x);
  endtask

  task automatic cp(input logic [3:0] d, input logic [3:0] s);
    drive("copy", 1'b1, 2'd1, s, 4'd0, d, 16'h0000);
  endtask

  task automatic add(input string tag, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    drive(tag, 1'b1, 2'd3, s1, s2, d, 16'h0000);
  endtask

  // Scoreboard monitor: compare the state produced by each clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, ".out"}, outreg_data, e.out);
        check({e.tag, ".sticky"}, {15'b0, ovf_sticky}, {15'b0, e.sticky});
      end
    end
  end

  initial begin
    logic [15:0] smp;
    logic [15:0] fsum;
    checks   = 0;
    errors   = 0;
    m_sticky = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    for (int i = 0; i < 4; i++) hist[i] = 16'h0000;
    n_reset = 1'b0; op = 2'd0; src1 = 4'd0; src2 = 4'd0; dest = 4'd0; ext_data = 16'h0000;

    drive("reset", 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
    drive("reset", 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0000);

    // LOAD then COPY, read back through r0
    ld(4'd7, 16'h1234);
    cp(4'd3, 4'd7);
    cp(4'd0, 4'd3);
    cp(4'd0, 4'd7);

    // simple add
    ld(4'd3, 16'h0005);
    ld(4'd4, 16'h0003);
    add("add_small", 4'd2, 4'd3, 4'd4);
    cp(4'd0, 4'd2);

    // positive overflow, sticky, cleared by LOAD
    ld(4'd3, 16'h7FFF);
    ld(4'd4, 16'h0001);
    add("add_povf", 4'd2, 4'd3, 4'd4);
    cp(4'd0, 4'd2);
    ld(4'd9, 16'hABCD);

    // negative overflow and non-overflowing wrap
    ld(4'd3, 16'h8000);
    ld(4'd4, 16'hFFFF);
    add("add_novf", 4'd2, 4'd3, 4'd4);
    cp(4'd0, 4'd2);
    ld(4'd3, 16'hFFFF);
    ld(4'd4, 16'h0001);
    add("add_wrap", 4'd2, 4'd3, 4'd4);
    cp(4'd0, 4'd2);

    // self-add with src1=src2=dest, and pre-edge read on r0
    ld(4'd5, 16'h4001);
    add("add_self", 4'd5, 4'd5, 4'd5);
    cp(4'd0, 4'd5);
    add("add_r0", 4'd0, 4'd0, 4'd0);

    // NOP addressing r15 must not write
    ld(4'd15, 16'h5A5A);
    drive("nop", 1'b1, 2'd0, 4'd3, 4'd4, 4'd15, 16'hFFFF);
    cp(4'd0, 4'd15);

    // reset between two adds, then reset with LOAD r5 pending
    ld(4'd3, 16'h7000);
    add("add_pre", 4'd1, 4'd3, 4'd3);
    drive("reset_mid", 1'b0, 2'd3, 4'd1, 4'd3, 4'd0, 16'h0000);
    add("add_post", 4'd0, 4'd1, 4'd3);
    ld(4'd6, 16'h1111);
    drive("reset_ld", 1'b0, 2'd2, 4'd0, 4'd0, 4'd5, 16'hBEEF);
    for (int i = 1; i < 16; i++) cp(4'd0, i[3:0]);

    // FIR: shift the delay line, then accumulate the four latest samples into r0
    for (int k = 0; k < 8; k++) begin
      smp = 16'($urandom_range(0, 16'h3FFF));
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = smp;
      ld(4'd7, smp);
      cp(4'd3, 4'd4);
      cp(4'd4, 4'd5);
      cp(4'd5, 4'd6);
      cp(4'd6, 4'd7);
      add("fir_a", 4'd2, 4'd3, 4'd4);
      add("fir_b", 4'd1, 4'd2, 4'd5);
      add("fir_c", 4'd0, 4'd1, 4'd6);
      @(posedge clk);
      #2;
      fsum = hist[0] + hist[1] + hist[2] + hist[3];
      check("fir_sum", outreg_data, fsum);
    end

    // random mix
    for (int k = 0; k < 40; k++) begin
      drive("rand", ($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 16'($urandom));
    end

    drive("idle", 1'b1, 2'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
    repeat (3) @(posedge clk);
    #3;
    check("drain", 16'(sb_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
